// File: rtl/sel_cmp_pkg.sv
// sel_cmp_pipe shared types and helpers.
// Compare-mode enum, compare function, clog2 with a floor of 1.
package sel_cmp_pkg;

  typedef enum logic [1:0] {
    CMP_GT = 2'b00,
    CMP_GE = 2'b01,
    CMP_EQ = 2'b10,
    CMP_LT = 2'b11
  } cmp_mode_e;

  localparam int CMP_MAXW = 64;

  function automatic logic cmp_fn(
    input cmp_mode_e             mode,
    input logic [CMP_MAXW-1:0]   a,
    input logic [CMP_MAXW-1:0]   b
  );
    logic r;
    r = 1'b0;
    case (mode)
      CMP_GT:  r = (a >  b);
      CMP_GE:  r = (a >= b);
      CMP_EQ:  r = (a == b);
      CMP_LT:  r = (a <  b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic int clog2m1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sel_cmp_pipe_prio_enc.sv
// sel_cmp_prio_enc: lowest-index-wins priority encoder.
// Produces any and the index of the lowest set request bit (0 if none).
module sel_cmp_prio_enc #(
  parameter int NCH = 4,
  parameter int IW  = 2
) (
  input  logic [NCH-1:0] req,
  output logic           any,
  output logic [IW-1:0]  idx
);

  // scan high to low so the lowest set bit is written last
  always_comb begin
    any = |req;
    idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/sel_cmp_pipe.sv
// sel_cmp_pipe: two-stage select/compare pipeline with valid/ready.
// Optional hit counters under SEL_CMP_PIPE_HITCNT_EN.
module sel_cmp_pipe
  import sel_cmp_pkg::*;
#(
  parameter int W    = 8,
  parameter int NCH  = 4,
  parameter int NSRC = 4,
  parameter int CNTW = 8,
  localparam int SW  = (NSRC > 1) ? $clog2(NSRC) : 1,
  localparam int IW  = clog2m1(NCH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NCH*NSRC*W-1:0]  src_data,
  input  logic [NCH*SW-1:0]      sel,
  input  logic [NCH*W-1:0]       thr,
  input  logic [NCH-1:0]         mask,
  input  logic [1:0]             mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NCH-1:0]         hit,
  output logic                   any_hit,
  output logic [IW-1:0]          first_idx
`ifdef SEL_CMP_PIPE_HITCNT_EN
  ,
  input  logic                   cnt_clr,
  output logic [NCH*CNTW-1:0]    hit_cnt
`endif
);

  logic             s1_valid;
  logic [NCH*W-1:0] s1_val;
  logic [NCH*W-1:0] s1_thr;
  logic [NCH-1:0]   s1_mask;
  cmp_mode_e        s1_mode;
  logic             s2_valid;
  logic             s1_adv;
  logic             s2_adv;
  logic [NCH*W-1:0] sval;
  logic [NCH-1:0]   hit_c;
  logic             any_c;
  logic [IW-1:0]    idx_c;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // per-channel field select
  always_comb begin
    sval = '0;
    for (int c = 0; c < NCH; c++) begin
      sval[c*W +: W] =
        src_data[(c*NSRC + int'(sel[c*SW +: SW]))*W +: W];
    end
  end

  // S1 register: selected fields, thresholds, mask, mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_val   <= '0;
      s1_thr   <= '0;
      s1_mask  <= '0;
      s1_mode  <= CMP_GT;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_val  <= sval;
        s1_thr  <= thr;
        s1_mask <= mask;
        s1_mode <= cmp_mode_e'(mode);
      end
    end
  end

  // masked unsigned compare per channel
  always_comb begin
    hit_c = '0;
    for (int c = 0; c < NCH; c++) begin
      hit_c[c] = s1_mask[c] &&
        cmp_fn(s1_mode,
               CMP_MAXW'(s1_val[c*W +: W]),
               CMP_MAXW'(s1_thr[c*W +: W]));
    end
  end

  sel_cmp_prio_enc #(
    .NCH (NCH),
    .IW  (IW)
  ) u_prio (
    .req (hit_c),
    .any (any_c),
    .idx (idx_c)
  );

  // S2 register: result flags, held while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      hit       <= '0;
      any_hit   <= 1'b0;
      first_idx <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        hit       <= hit_c;
        any_hit   <= any_c;
        first_idx <= idx_c;
      end
    end
  end

`ifdef SEL_CMP_PIPE_HITCNT_EN
  // saturating per-channel hit counters, clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt <= '0;
    end else if (cnt_clr) begin
      hit_cnt <= '0;
    end else if (out_valid && out_ready) begin
      for (int c = 0; c < NCH; c++) begin
        if (hit[c] && (hit_cnt[c*CNTW +: CNTW] != {CNTW{1'b1}}))
          hit_cnt[c*CNTW +: CNTW] <= hit_cnt[c*CNTW +: CNTW] + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sel_cmp_pipe.sv
// tb_sel_cmp_pipe: randomized self-checking bench for sel_cmp_pipe.
// Reference model computes results straight from the selection/compare rules.
module tb_sel_cmp_pipe;

  localparam int W    = 8;
  localparam int NCH  = 4;
  localparam int NSRC = 4;
  localparam int CNTW = 8;
  localparam int SW   = 2;
  localparam int IW   = 2;
  localparam int RW   = NCH + 1 + IW;

  logic                  clk = 0;
  logic                  rst_n = 0;
  logic                  in_valid = 0;
  logic                  in_ready;
  logic [NCH*NSRC*W-1:0] src_data = '0;
  logic [NCH*SW-1:0]     sel = '0;
  logic [NCH*W-1:0]      thr = '0;
  logic [NCH-1:0]        mask = '0;
  logic [1:0]            mode = '0;
  logic                  out_valid;
  logic                  out_ready = 1;
  logic [NCH-1:0]        hit;
  logic                  any_hit;
  logic [IW-1:0]         first_idx;
`ifdef SEL_CMP_PIPE_HITCNT_EN
  logic                  cnt_clr = 0;
  logic [NCH*CNTW-1:0]   hit_cnt;
`endif

  int vec = 0;
  int err = 0;
  int cyc = 0;

  logic [RW-1:0] expq[$];
  logic [RW-1:0] gotq[$];
  int            stq[$];

  sel_cmp_pipe #(
    .W(W), .NCH(NCH), .NSRC(NSRC), .CNTW(CNTW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .src_data(src_data), .sel(sel), .thr(thr),
    .mask(mask), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .hit(hit), .any_hit(any_hit), .first_idx(first_idx)
`ifdef SEL_CMP_PIPE_HITCNT_EN
    , .cnt_clr(cnt_clr), .hit_cnt(hit_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [RW-1:0] model(
    input logic [NCH*NSRC*W-1:0] s,
    input logic [NCH*SW-1:0]     sl,
    input logic [NCH*W-1:0]      t,
    input logic [NCH-1:0]        m,
    input logic [1:0]            md
  );
    logic [NCH-1:0] h;
    int f;
    h = '0;
    f = 0;
    for (int c = 0; c < NCH; c++) begin
      int src;
      int unsigned v, th;
      src = int'(sl[c*SW +: SW]);
      v   = s[(c*NSRC + src)*W +: W];
      th  = t[c*W +: W];
      case (md)
        2'd0: h[c] = m[c] && (v > th);
        2'd1: h[c] = m[c] && (v >= th);
        2'd2: h[c] = m[c] && (v == th);
        default: h[c] = m[c] && (v < th);
      endcase
    end
    for (int c = NCH - 1; c >= 0; c--) if (h[c]) f = c;
    return {h, |h, IW'(f)};
  endfunction

  // observe accepts and emissions at negedge, when handshakes are stable
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready)
        expq.push_back(model(src_data, sel, thr, mask, mode));
      if (out_valid && out_ready) begin
        gotq.push_back({hit, any_hit, first_idx});
        stq.push_back(cyc);
      end
    end
  end

  task automatic clear_q();
    expq.delete();
    gotq.delete();
    stq.delete();
  endtask

  task automatic send(
    input logic [NCH*NSRC*W-1:0] s,
    input logic [NCH*SW-1:0]     sl,
    input logic [NCH*W-1:0]      t,
    input logic [NCH-1:0]        m,
    input logic [1:0]            md
  );
    bit ok, a;
    src_data = s; sel = sl; thr = t; mask = m; mode = md;
    in_valid = 1;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); a = in_ready;
      @(posedge clk); #1;
      if (a) begin ok = 1; break; end
    end
    vec++;
    if (!ok) begin
      err++;
      $display("FAIL send_timeout in_ready stuck at %0b, required 1", in_ready);
    end
  endtask

  task automatic rnd_send();
    logic [NCH*NSRC*W-1:0] s;
    for (int i = 0; i < NCH*NSRC*W/32; i++) s[i*32 +: 32] = $urandom;
    send(s, NCH*SW'($urandom), NCH*W'($urandom),
         NCH'($urandom), 2'($urandom));
  endtask

  task automatic test_reset();
    rst_n = 0;
    #12;
    vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL rst_out_valid got %0b req 0", out_valid); end
    vec++; if (hit !== '0) begin err++; $display("FAIL rst_hit got %0h req 0", hit); end
    vec++; if (any_hit !== 1'b0 || first_idx !== '0) begin err++; $display("FAIL rst_any_first got %0b/%0d req 0/0", any_hit, first_idx); end
    vec++; if (in_ready !== 1'b1) begin err++; $display("FAIL rst_in_ready got %0b req 1", in_ready); end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_gt();
    logic [NCH*NSRC*W-1:0] s;
    int vals[4] = '{10, 50, 200, 7};
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < NSRC; k++)
        s[(c*NSRC+k)*W +: W] = (k == 2) ? W'(vals[c]) : W'($urandom);
    send(s, {4{2'd2}}, {4{8'd40}}, 4'hF, 2'b00);
    in_valid = 0;
    @(negedge clk);
    vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL gt_latency1 out_valid got %0b req 0", out_valid); end
    @(posedge clk); @(negedge clk);
    vec++; if (out_valid !== 1'b1) begin err++; $display("FAIL gt_latency2 out_valid got %0b req 1", out_valid); end
    vec++; if ({hit, any_hit, first_idx} !== {4'b0110, 1'b1, 2'd1}) begin
      err++; $display("FAIL gt_result got hit=%b any=%b idx=%0d req hit=0110 any=1 idx=1", hit, any_hit, first_idx);
    end
    @(posedge clk); #1;
    clear_q();
  endtask

  task automatic test_eq_mask();
    logic [NCH*NSRC*W-1:0] s;
    for (int i = 0; i < 4; i++) s[i*32 +: 32] = $urandom;
    s[(3*NSRC+1)*W +: W] = 8'hFF;
    for (int pass = 0; pass < 2; pass++) begin
      send(s, {2'd1, 6'($urandom)}, {8'hFF, 24'($urandom)},
           (pass == 0) ? 4'b1000 : 4'b0000, 2'b10);
      in_valid = 0;
      @(posedge clk); @(negedge clk);
      vec++; if (out_valid !== 1'b1) begin err++; $display("FAIL eq_valid pass%0d got %0b req 1", pass, out_valid); end
      if (pass == 0) begin
        vec++; if ({hit, any_hit, first_idx} !== {4'b1000, 1'b1, 2'd3}) begin
          err++; $display("FAIL eq_ch3 got hit=%b any=%b idx=%0d req 1000/1/3", hit, any_hit, first_idx);
        end
      end else begin
        vec++; if ({hit, any_hit, first_idx} !== '0) begin
          err++; $display("FAIL eq_mask0 got hit=%b any=%b idx=%0d req 0/0/0", hit, any_hit, first_idx);
        end
      end
      @(posedge clk); #1;
    end
    clear_q();
  endtask

  task automatic test_boundary();
    logic [3:0] req[3] = '{4'h0, 4'hF, 4'hF};
    logic [7:0] v[3]   = '{8'h80, 8'h80, 8'h7F};
    logic [1:0] md[3]  = '{2'b11, 2'b01, 2'b11};
    for (int i = 0; i < 3; i++) begin
      send({16{v[i]}}, 8'($urandom), {4{8'h80}}, 4'hF, md[i]);
      in_valid = 0;
      @(posedge clk); @(negedge clk);
      vec++; if (out_valid !== 1'b1 || hit !== req[i]) begin
        err++; $display("FAIL boundary%0d got valid=%b hit=%b req 1/%b", i, out_valid, hit, req[i]);
      end
      @(posedge clk); #1;
    end
    clear_q();
  endtask

  task automatic test_back_to_back();
    clear_q();
    out_ready = 1;
    for (int i = 0; i < 8; i++) rnd_send();
    in_valid = 0;
    for (int i = 0; i < 20 && gotq.size() < 8; i++) @(posedge clk);
    #1;
    vec++; if (gotq.size() != 8 || expq.size() != 8) begin
      err++; $display("FAIL b2b_count got %0d/%0d req 8", gotq.size(), expq.size());
    end
    for (int i = 0; i < gotq.size() && i < expq.size(); i++) begin
      vec++; if (gotq[i] !== expq[i]) begin err++; $display("FAIL b2b_beat%0d got %h req %h", i, gotq[i], expq[i]); end
    end
    for (int i = 1; i < stq.size(); i++) begin
      vec++; if (stq[i] != stq[i-1] + 1) begin err++; $display("FAIL b2b_gap%0d got cyc %0d req %0d", i, stq[i], stq[i-1] + 1); end
    end
    clear_q();
  endtask

  task automatic test_stall();
    logic [RW+1:0] prev;
    clear_q();
    fork
      begin
        for (int i = 0; i < 12; i++) rnd_send();
        in_valid = 0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          if (k > 0) begin
            vec++; if ({out_valid, in_ready, hit, any_hit, first_idx} !== prev) begin
              err++; $display("FAIL stall_hold%0d got %h req %h", k, {out_valid, in_ready, hit, any_hit, first_idx}, prev);
            end
          end
          if (k == 2) begin
            vec++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
              err++; $display("FAIL stall_full got in_ready=%b out_valid=%b req 0/1", in_ready, out_valid);
            end
          end
          prev = {out_valid, in_ready, hit, any_hit, first_idx};
          @(posedge clk); #1;
        end
        out_ready = 1;
      end
    join
    for (int i = 0; i < 20 && gotq.size() < 12; i++) @(posedge clk);
    #1;
    vec++; if (gotq.size() != 12 || expq.size() != 12) begin
      err++; $display("FAIL stall_count got %0d/%0d req 12", gotq.size(), expq.size());
    end
    for (int i = 0; i < gotq.size() && i < expq.size(); i++) begin
      vec++; if (gotq[i] !== expq[i]) begin err++; $display("FAIL stall_beat%0d got %h req %h", i, gotq[i], expq[i]); end
    end
    clear_q();
  endtask

  task automatic test_random();
    bit done;
    done = 0;
    clear_q();
    fork
      begin
        for (int i = 0; i < 40; i++) rnd_send();
        in_valid = 0;
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1;
      end
    join
    for (int i = 0; i < 50 && gotq.size() < expq.size(); i++) @(posedge clk);
    #1;
    vec++; if (gotq.size() != 40 || expq.size() != 40) begin
      err++; $display("FAIL rand_count got %0d/%0d req 40", gotq.size(), expq.size());
    end
    for (int i = 0; i < gotq.size() && i < expq.size(); i++) begin
      vec++; if (gotq[i] !== expq[i]) begin err++; $display("FAIL rand_beat%0d got %h req %h", i, gotq[i], expq[i]); end
    end
    clear_q();
  endtask

  task automatic test_reset_mid();
    logic [NCH*NSRC*W-1:0] s;
    logic [NCH*SW-1:0] sl;
    logic [NCH*W-1:0] t;
    logic [RW-1:0] want;
    out_ready = 1;
    rnd_send();
    rnd_send();
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    vec++; if (out_valid !== 1'b0 || hit !== '0) begin
      err++; $display("FAIL rstmid_flush got valid=%b hit=%b req 0/0", out_valid, hit);
    end
    clear_q();
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) s[i*32 +: 32] = $urandom;
    sl = 8'($urandom);
    t = 32'($urandom);
    want = model(s, sl, t, 4'hF, 2'b01);
    send(s, sl, t, 4'hF, 2'b01);
    in_valid = 0;
    repeat (4) @(posedge clk);
    #1;
    vec++; if (gotq.size() != 1) begin err++; $display("FAIL rstmid_count got %0d req 1", gotq.size()); end
    vec++; if (gotq.size() < 1 || gotq[0] !== want) begin
      err++; $display("FAIL rstmid_first got %h req %h", (gotq.size() > 0) ? gotq[0] : '0, want);
    end
    clear_q();
  endtask

`ifdef SEL_CMP_PIPE_HITCNT_EN
  task automatic test_hitcnt();
    out_ready = 1;
    cnt_clr = 1;
    @(posedge clk); #1;
    cnt_clr = 0;
    for (int i = 0; i < 300; i++)
      send({16{8'($urandom)}}, 8'($urandom), '0, 4'b0001, 2'b01);
    in_valid = 0;
    repeat (4) @(posedge clk);
    #1;
    vec++; if (hit_cnt[7:0] !== 8'hFF) begin err++; $display("FAIL cnt_sat got %0d req 255", hit_cnt[7:0]); end
    vec++; if (hit_cnt[31:8] !== '0) begin err++; $display("FAIL cnt_others got %h req 0", hit_cnt[31:8]); end
    send({16{8'h01}}, 8'($urandom), '0, 4'b0001, 2'b01);
    in_valid = 0;
    @(posedge clk); #1;
    cnt_clr = 1;
    @(negedge clk);
    vec++; if (out_valid !== 1'b1 || hit[0] !== 1'b1) begin
      err++; $display("FAIL cnt_clr_setup got valid=%b hit0=%b req 1/1", out_valid, hit[0]);
    end
    @(posedge clk); #1;
    cnt_clr = 0;
    vec++; if (hit_cnt[7:0] !== 8'h00) begin err++; $display("FAIL cnt_clr_prio got %0d req 0", hit_cnt[7:0]); end
    clear_q();
  endtask
`endif

  initial begin
    test_reset();
    test_gt();
    test_eq_mask();
    test_boundary();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_mid();
`ifdef SEL_CMP_PIPE_HITCNT_EN
    test_hitcnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
